alu_arbiter: RTL and testbench

Shares the single 32-bit ALU (add/sub/and/or/SLT datapath) between two requesters. Arbitrates with a valid/ready handshake, registers the winner's operands and ALUControl code, and drives them to the ALU for one full cycle. Captures the result and zero flag, then returns them on a shared response channel tagged with the requester ID. Sits between the two issue sources (main datapath and compare/branch unit) and the combinational ALU.

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels, the registered ALU drive/return and the tagged response channel.
// The arbiter takes the slave view; the environment (requesters, ALU, response consumer) takes the master view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: legal op responds 2 cycles after accept, illegal op 1 cycle; response held until rsp_ready.
// Fixed priority (requester 0) by default; define ALU_ARB_RR_EN for round-robin on simultaneous requests.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic             any_vld;
    logic             accept;
    logic             win;
    logic             op_legal;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign any_vld = bus.req0_valid | bus.req1_valid;
    assign accept  = (state_q == IDLE) && any_vld;

`ifdef ALU_ARB_RR_EN
    // On contention the requester that did not win last time goes next.
    assign win = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : ~bus.req0_valid;
`else
    assign win = ~bus.req0_valid;
`endif

    assign bus.req0_ready = accept & ~win;
    assign bus.req1_ready = accept &  win;

    assign sel_op   = win ? bus.req1_op : bus.req0_op;
    assign sel_a    = win ? bus.req1_a  : bus.req0_a;
    assign sel_b    = win ? bus.req1_b  : bus.req0_b;
    assign op_legal = sel_op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    grant_id_d   = win;
                    last_grant_d = win;
                    if (op_legal) begin
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_ctl_d = sel_op;
                        state_d   = EXEC;
                    end else begin
                        // Illegal codes never reach the ALU; answer directly with an error.
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_result_d = bus.alu_result;
                rsp_zero_d   = bus.alu_zero;
                rsp_err_d    = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctl_q    <= 3'b000;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_control = alu_ctl_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = grant_id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Define ALU_ARB_RR_EN here as well as in the RTL to check the round-robin build.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int W = 32;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mdl_last = 1'b1;

    int          o_win, o_lat, o_hold_bad;
    logic        o_id, o_zero, o_err;
    logic [31:0] o_res;
    longint      o_acc_t;

    alu_arbiter_if #(.WIDTH(W)) bus();
    alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU.
    always_comb begin
        case (bus.alu_control)
            3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b101:  bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: bus.alu_result = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_result == 32'd0);
    end

    // Expected response {err, zero, result} for one operation.
    function automatic logic [33:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        if (op == 3'd0)      r = a + b;
        else if (op == 3'd1) r = a - b;
        else if (op == 3'd2) r = a & b;
        else if (op == 3'd3) r = a | b;
        else if (op == 3'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else begin
            r = 32'd0;
            e = 1'b1;
        end
        return {e, (!e && r == 32'd0), r};
    endfunction

    function automatic bit ref_win(input bit v0, input bit v1);
`ifdef ALU_ARB_RR_EN
        if (v0 && v1) return !mdl_last;
`endif
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_last = 1'b1;
    endtask

    // Drives one arbitration round and records what the DUT did; valids stay up until release.
    task automatic transact(input bit v0, input bit v1, input logic [2:0] op0, input logic [2:0] op1,
                            input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1, input int stall);
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = (stall == 0);
        o_win = -1;
        o_hold_bad = 0;
        for (int t = 0; t < 20 && o_win < 0; t++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) o_win = 2;
            else if (bus.req0_ready)              o_win = 0;
            else if (bus.req1_ready)              o_win = 1;
        end
        @(posedge clk);
        o_acc_t = longint'($time);
        #1;
        bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_a = $urandom; bus.req1_b = $urandom;
        o_lat = 0;
        do begin
            @(negedge clk);
            o_lat++;
            if (!bus.rsp_valid && (bus.req0_ready || bus.req1_ready)) o_hold_bad++;
        end while (!bus.rsp_valid && o_lat < 10);
        o_id = bus.rsp_id; o_res = bus.rsp_result; o_zero = bus.rsp_zero; o_err = bus.rsp_err;
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_id !== o_id || bus.rsp_result !== o_res ||
                bus.rsp_zero !== o_zero || bus.rsp_err !== o_err || bus.req0_ready || bus.req1_ready)
                o_hold_bad++;
            if (i == stall) bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic test_reset();
        bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 000000", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err});
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_control, bus.rsp_result} !== 99'd0) begin
            miscompares++;
            $display("FAIL reset_data: alu_a %h alu_b %h ctl %b res %h required all zero", bus.alu_a, bus.alu_b, bus.alu_control, bus.rsp_result);
        end
        reset = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_add();
        transact(1'b1, 1'b0, OP_ADD, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 0);
        mdl_last = 1'b0;
        vectors++;
        if (o_win !== 0 || o_lat !== 2) begin
            miscompares++;
            $display("FAIL add_timing: win %0d lat %0d required win 0 lat 2", o_win, o_lat);
        end
        vectors++;
        if ({o_id, o_zero, o_err, o_res} !== {1'b0, 1'b0, 1'b0, 32'd12}) begin
            miscompares++;
            $display("FAIL add_rsp: id %b zero %b err %b res %0d required 0 0 0 12", o_id, o_zero, o_err, o_res);
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_control} !== {32'd5, 32'd7, OP_ADD} || o_hold_bad !== 0) begin
            miscompares++;
            $display("FAIL add_alu_hold: alu_a %0d alu_b %0d ctl %b hold_bad %0d required 5 7 000 0", bus.alu_a, bus.alu_b, bus.alu_control, o_hold_bad);
        end
    endtask

    task automatic test_slt();
        transact(1'b0, 1'b1, OP_ADD, OP_SLT, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 0);
        mdl_last = 1'b1;
        vectors++;
        if ({o_id, o_zero, o_err, o_res} !== {1'b1, 1'b0, 1'b0, 32'd1} || o_win !== 1) begin
            miscompares++;
            $display("FAIL slt_neg: win %0d id %b zero %b err %b res %0d required 1 1 0 0 1", o_win, o_id, o_zero, o_err, o_res);
        end
        transact(1'b0, 1'b1, OP_ADD, OP_SLT, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
        vectors++;
        if ({o_id, o_zero, o_err, o_res} !== {1'b1, 1'b1, 1'b0, 32'd0} || o_lat !== 2) begin
            miscompares++;
            $display("FAIL slt_pos: lat %0d id %b zero %b err %b res %0d required 2 1 1 0 0", o_lat, o_id, o_zero, o_err, o_res);
        end
    endtask

    task automatic test_stall();
        bit exp_w;
        exp_w = ref_win(1'b1, 1'b1);
        transact(1'b1, 1'b1, OP_SUB, OP_SUB, 32'd9, 32'd9, 32'd9, 32'd9, 5);
        mdl_last = exp_w;
        vectors++;
        if (o_hold_bad !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: %0d unstable or ready-high cycles, required 0", o_hold_bad);
        end
        vectors++;
        if ({o_id, o_zero, o_err, o_res} !== {exp_w, 1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL stall_rsp: id %b zero %b err %b res %0d required %b 1 0 0", o_id, o_zero, o_err, o_res, exp_w);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: rsp_valid %b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_illegal();
        transact(1'b1, 1'b0, 3'b110, OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 0);
        mdl_last = 1'b0;
        vectors++;
        if (o_lat !== 1 || {o_id, o_zero, o_err, o_res} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL illegal_rsp: lat %0d id %b zero %b err %b res %0d required 1 0 0 1 0", o_lat, o_id, o_zero, o_err, o_res);
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_control} !== {32'd9, 32'd9, OP_SUB}) begin
            miscompares++;
            $display("FAIL illegal_alu: alu_a %0d alu_b %0d ctl %b required 9 9 001", bus.alu_a, bus.alu_b, bus.alu_control);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic [33:0] exp;
        bit          exp_w;
        longint      prev_t;
        do_reset();
        prev_t = 0;
        for (int i = 0; i < 4; i++) begin
            op0 = 3'($urandom_range(0, 3)); op1 = OP_SLT;
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            exp_w = ref_win(1'b1, 1'b1);
            exp = exp_w ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
            transact(1'b1, 1'b1, op0, op1, a0, b0, a1, b1, 0);
            mdl_last = exp_w;
            vectors++;
            if (o_id !== exp_w || o_res !== exp[31:0] || o_zero !== exp[32]) begin
                miscompares++;
                $display("FAIL b2b_seq[%0d]: id %b res %h zero %b required %b %h %b", i, o_id, o_res, o_zero, exp_w, exp[31:0], exp[32]);
            end
            vectors++;
            if (i > 0 && o_acc_t - prev_t != 30) begin
                miscompares++;
                $display("FAIL b2b_rate[%0d]: accept spacing %0d ns required 30", i, o_acc_t - prev_t);
            end
            prev_t = o_acc_t;
        end
        for (int i = 0; i < 2; i++) begin
            transact(1'b0, 1'b1, OP_ADD, 3'b111, 32'd0, 32'd0, 32'd1, 32'd2, 0);
            mdl_last = 1'b1;
            vectors++;
            if (o_err !== 1'b1 || (i > 0 && o_acc_t - prev_t != 20)) begin
                miscompares++;
                $display("FAIL b2b_illegal[%0d]: err %b spacing %0d ns required 1 and 20", i, o_err, o_acc_t - prev_t);
            end
            prev_t = o_acc_t;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 32'hF0; bus.req0_b = 32'hFF;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_accept: req0_ready %b required 1", bus.req0_ready);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_control, bus.rsp_result} !== 103'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: rsp_valid %b alu_a %h alu_b %h ctl %b required all zero", bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_control);
        end
        reset = 1'b0;
        mdl_last = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_rsp: rsp_valid seen %0d cycles required 0", seen);
        end
        transact(1'b1, 1'b1, OP_ADD, OP_SUB, 32'd1, 32'd2, 32'd10, 32'd3, 0);
        mdl_last = 1'b0;
        vectors++;
        if (o_win !== 0 || {o_id, o_res} !== {1'b0, 32'd3} || o_lat !== 2) begin
            miscompares++;
            $display("FAIL rstmid_first: win %0d id %b res %0d lat %0d required 0 0 3 2", o_win, o_id, o_res, o_lat);
        end
    endtask

    task automatic test_random();
        bit          v0, v1, exp_w;
        logic [2:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic [33:0] exp;
        int          stall;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            stall = $urandom_range(0, 3);
            exp_w = ref_win(v0, v1);
            exp = exp_w ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
            transact(v0, v1, op0, op1, a0, b0, a1, b1, stall);
            mdl_last = exp_w;
            vectors++;
            if (o_win !== int'(exp_w) || o_id !== exp_w) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: win %0d id %b required %b", i, o_win, o_id, exp_w);
            end
            vectors++;
            if ({o_err, o_zero, o_res} !== exp || o_lat !== (exp[33] ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rand_rsp[%0d]: err %b zero %b res %h lat %0d required %b %b %h %0d", i, o_err, o_zero, o_res, o_lat, exp[33], exp[32], exp[31:0], exp[33] ? 1 : 2);
            end
            vectors++;
            if (o_hold_bad !== 0) begin
                miscompares++;
                $display("FAIL rand_hold[%0d]: %0d bad cycles required 0", i, o_hold_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
